// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port arbiter
interface mem_port_arbiter_if #(parameter int XLEN = 32);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_flush;
    logic            if_valid;
    logic [XLEN-1:0] if_rdata;
    logic            d_req;
    logic            d_we;
    logic [1:0]      d_size;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_valid;
    logic [XLEN-1:0] d_rdata;
    logic            d_misalign;
    logic            stall;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush, d_req, d_we, d_size, d_addr, d_wdata, mem_ready, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata, d_misalign, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output if_req, if_addr, if_flush, d_req, d_we, d_size, d_addr, d_wdata, mem_ready, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata, d_misalign, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data accesses
module mem_port_arbiter #(
    parameter int XLEN        = 32,
    parameter int DSTREAK_MAX = 2
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(DSTREAK_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(DSTREAK_MAX);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, DRAIN} state_t;

    state_t          r_state;
    logic [SW-1:0]   r_streak;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_rdata;
    logic            r_d_valid;
    logic [XLEN-1:0] r_d_rdata;
    logic            r_d_misalign;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [3:0]      r_mem_be;
    logic [XLEN-1:0] r_mem_wdata;
    logic [1:0]      r_size;
    logic [1:0]      r_a;

    logic            w_fetch_ok;
    logic            w_fetch_pri;
    logic            w_grant_d;
    logic            w_grant_f;
    logic            w_mis;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_ld;

    always_comb begin
        w_fetch_ok  = bus.if_req & ~bus.if_flush;
        w_fetch_pri = w_fetch_ok & (r_streak >= SMAX);
        w_grant_d   = bus.d_req & ~w_fetch_pri;
        w_grant_f   = w_fetch_ok & (~bus.d_req | w_fetch_pri);
        w_mis       = (bus.d_size == 2'd3) | (bus.d_size == 2'd2 && bus.d_addr[1:0] != 2'd0) |
                      (bus.d_size == 2'd1 && bus.d_addr[0]);
        w_be        = bus.d_size == 2'd0 ? 4'b1000 >> bus.d_addr[1:0] :
                      bus.d_size == 2'd1 ? 4'b1100 >> bus.d_addr[1:0] : 4'hF;
        w_wdata     = bus.d_size == 2'd0 ? XLEN'({4{bus.d_wdata[7:0]}}) :
                      bus.d_size == 2'd1 ? XLEN'({2{bus.d_wdata[15:0]}}) : bus.d_wdata;
        // Shifting by the byte offset brings the addressed lane to the top
        w_sh        = bus.mem_rdata << {r_a, 3'b000};
        w_ld        = r_size == 2'd0 ? w_sh & ~({XLEN{1'b1}} >> 8) :
                      r_size == 2'd1 ? w_sh & ~({XLEN{1'b1}} >> 16) : bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_streak     <= '0;
            r_if_valid   <= 1'b0;
            r_if_rdata   <= '0;
            r_d_valid    <= 1'b0;
            r_d_rdata    <= '0;
            r_d_misalign <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= 4'h0;
            r_mem_wdata  <= '0;
            r_size       <= 2'd0;
            r_a          <= 2'd0;
        end else begin
            r_if_valid   <= 1'b0;
            r_d_valid    <= 1'b0;
            r_d_misalign <= 1'b0;
            if (r_state == IDLE) begin
                r_streak <= (w_grant_f || !bus.if_req) ? '0 :
                            (w_grant_d && r_streak < SMAX) ? r_streak + 1'b1 : r_streak;
                if (w_grant_d && w_mis) begin
                    r_d_misalign <= 1'b1;
                end else if (w_grant_d) begin
                    r_state     <= DATA;
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= bus.d_we;
                    r_mem_be    <= w_be;
                    r_mem_addr  <= bus.d_addr & ~XLEN'(3);
                    r_mem_wdata <= w_wdata;
                    r_size      <= bus.d_size;
                    r_a         <= bus.d_addr[1:0];
                end else if (w_grant_f) begin
                    r_state    <= FETCH;
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_be   <= 4'hF;
                    r_mem_addr <= bus.if_addr & ~XLEN'(3);
                end
            end else if (bus.mem_ready) begin
                r_state    <= IDLE;
                r_mem_req  <= 1'b0;
                r_mem_we   <= 1'b0;
                r_mem_be   <= 4'h0;
                r_if_valid <= r_state == FETCH && !bus.if_flush;
                r_d_valid  <= r_state == DATA;
                if (r_state == FETCH) r_if_rdata <= bus.mem_rdata;
                if (r_state == DATA) r_d_rdata <= w_ld;
            end else if (r_state == FETCH && bus.if_flush) begin
                r_state <= DRAIN;
            end
        end
    end

    assign bus.if_valid   = r_if_valid;
    assign bus.if_rdata   = r_if_rdata;
    assign bus.d_valid    = r_d_valid;
    assign bus.d_rdata    = r_d_rdata;
    assign bus.d_misalign = r_d_misalign;
    assign bus.stall      = bus.d_req & ~(r_d_valid | r_d_misalign);
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_be     = r_mem_be;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario tests for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(32)) bus ();
    mem_port_arbiter #(.XLEN(32), .DSTREAK_MAX(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] exp_w;
        logic [31:0] exp_r;
    } lane_vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_size = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
    endtask

    task automatic test_reset;
        reset = 0;
        idle_in();
        tick();
        tick();
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.if_valid, bus.d_valid, bus.d_misalign, bus.stall} !== 10'd0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0", {bus.mem_req, bus.mem_we, bus.mem_be, bus.if_valid, bus.d_valid, bus.d_misalign, bus.stall});
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== 128'd0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata});
        end
        reset = 1;
        tick();
    endtask

    task automatic test_fetch;
        bus.if_req = 1; bus.if_addr = 32'h100;
        tick();
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
            bad++; $display("FAIL fetch_issue got=%h want=%h", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b1, 1'b0, 4'hF, 32'h100});
        end
        bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
        tick();
        total++;
        if ({bus.if_valid, bus.if_rdata, bus.mem_req} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            bad++; $display("FAIL fetch_done got=%h want=%h", {bus.if_valid, bus.if_rdata, bus.mem_req}, {1'b1, 32'hDEADBEEF, 1'b0});
        end
        bus.mem_ready = 0;
        tick();
        total++;
        if (bus.if_valid !== 1'b0) begin
            bad++; $display("FAIL fetch_pulse got=%b want=0", bus.if_valid);
        end
    endtask

    task automatic test_byte_load;
        bus.d_req = 1; bus.d_we = 0; bus.d_size = 0; bus.d_addr = 32'h203;
        #1;
        total++;
        if (bus.stall !== 1'b1) begin
            bad++; $display("FAIL bl_stall_req got=%b want=1", bus.stall);
        end
        tick();
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'b0001, 32'h200}) begin
            bad++; $display("FAIL bl_issue got=%h want=%h", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b1, 1'b0, 4'b0001, 32'h200});
        end
        tick();
        total++;
        if ({bus.mem_req, bus.mem_be, bus.stall, bus.d_valid} !== {1'b1, 4'b0001, 1'b1, 1'b0}) begin
            bad++; $display("FAIL bl_hold got=%b want=%b", {bus.mem_req, bus.mem_be, bus.stall, bus.d_valid}, {1'b1, 4'b0001, 1'b1, 1'b0});
        end
        bus.mem_ready = 1; bus.mem_rdata = 32'h11223344;
        tick();
        total++;
        if ({bus.d_valid, bus.d_rdata, bus.stall, bus.mem_req} !== {1'b1, 32'h44000000, 1'b0, 1'b0}) begin
            bad++; $display("FAIL bl_done got=%h want=%h", {bus.d_valid, bus.d_rdata, bus.stall, bus.mem_req}, {1'b1, 32'h44000000, 1'b0, 1'b0});
        end
        bus.d_req = 0; bus.mem_ready = 0;
        tick();
        total++;
        if ({bus.d_valid, bus.mem_req, bus.mem_be} !== 6'd0) begin
            bad++; $display("FAIL bl_idle got=%b want=0", {bus.d_valid, bus.mem_req, bus.mem_be});
        end
    endtask

    task automatic test_lanes;
        lane_vec_t v[6] = '{
            '{1'b1, 2'd1, 32'h12, 32'hABCD, 32'h0, 4'b0011, 32'hABCDABCD, 32'h0},
            '{1'b1, 2'd0, 32'h31, 32'h5A, 32'h0, 4'b0100, 32'h5A5A5A5A, 32'h0},
            '{1'b1, 2'd2, 32'h44, 32'h12345678, 32'h0, 4'b1111, 32'h12345678, 32'h0},
            '{1'b0, 2'd1, 32'h50, 32'h0, 32'h11223344, 4'b1100, 32'h0, 32'h11220000},
            '{1'b0, 2'd0, 32'h61, 32'h0, 32'h11223344, 4'b0100, 32'h0, 32'h22000000},
            '{1'b0, 2'd2, 32'h78, 32'h0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D}
        };
        for (int i = 0; i < 6; i++) begin
            bus.d_req = 1; bus.d_we = v[i].we; bus.d_size = v[i].size; bus.d_addr = v[i].addr; bus.d_wdata = v[i].wdata;
            tick();
            total++;
            if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, v[i].we, v[i].be, v[i].addr & ~32'h3}) begin
                bad++; $display("FAIL lane%0d_issue got=%h want=%h", i, {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b1, v[i].we, v[i].be, v[i].addr & ~32'h3});
            end
            if (v[i].we) begin
                total++;
                if (bus.mem_wdata !== v[i].exp_w) begin
                    bad++; $display("FAIL lane%0d_wdata got=%h want=%h", i, bus.mem_wdata, v[i].exp_w);
                end
            end
            bus.mem_ready = 1; bus.mem_rdata = v[i].rdata;
            tick();
            total++;
            if (bus.d_valid !== 1'b1 || (!v[i].we && bus.d_rdata !== v[i].exp_r)) begin
                bad++; $display("FAIL lane%0d_done got=%b/%h want=1/%h", i, bus.d_valid, bus.d_rdata, v[i].exp_r);
            end
            bus.d_req = 0; bus.mem_ready = 0;
            tick();
            total++;
            if ({bus.mem_we, bus.mem_be} !== 5'd0) begin
                bad++; $display("FAIL lane%0d_idle got=%b want=0", i, {bus.mem_we, bus.mem_be});
            end
        end
    endtask

    task automatic test_back_to_back;
        bus.d_req = 1; bus.d_we = 0; bus.d_size = 2; bus.d_addr = 32'h20; bus.mem_ready = 1;
        tick();
        tick();
        total++;
        if ({bus.d_valid, bus.mem_req} !== 2'b10) begin
            bad++; $display("FAIL b2b_gap got=%b want=10", {bus.d_valid, bus.mem_req});
        end
        tick();
        total++;
        if ({bus.d_valid, bus.mem_req} !== 2'b01) begin
            bad++; $display("FAIL b2b_reissue got=%b want=01", {bus.d_valid, bus.mem_req});
        end
        bus.d_req = 0;
        tick();
        bus.mem_ready = 0;
        tick();
    endtask

    task automatic test_starvation;
        logic got[6];
        logic expd[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int   n = 0;
        bus.if_req = 1; bus.if_addr = 32'h400;
        bus.d_req = 1; bus.d_we = 0; bus.d_size = 2; bus.d_addr = 32'h300; bus.mem_ready = 1;
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick();
            if (bus.mem_req) begin
                got[n] = bus.mem_addr == 32'h400;
                n++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= n || got[i] !== expd[i]) begin
                bad++; $display("FAIL starve_grant%0d got=%b want=%b (grants seen %0d)", i, i < n ? got[i] : 1'bx, expd[i], n);
            end
        end
        bus.if_req = 0; bus.d_req = 0;
        tick();
        bus.mem_ready = 0;
        tick();
    endtask

    task automatic test_flush;
        bus.if_req = 1; bus.if_addr = 32'h500;
        tick();
        bus.if_req = 0; bus.if_flush = 1;
        tick();
        bus.if_flush = 0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h500}) begin
                bad++; $display("FAIL flush_hold%0d got=%h want=%h", i, {bus.mem_req, bus.mem_addr}, {1'b1, 32'h500});
            end
            tick();
        end
        bus.mem_ready = 1; bus.mem_rdata = 32'hBAD0BAD0;
        tick();
        total++;
        if ({bus.if_valid, bus.mem_req} !== 2'b00) begin
            bad++; $display("FAIL flush_drain got=%b want=00", {bus.if_valid, bus.mem_req});
        end
        bus.mem_ready = 0;
        bus.if_req = 1; bus.if_flush = 1; bus.if_addr = 32'h600;
        tick();
        total++;
        if ({bus.if_valid, bus.mem_req} !== 2'b00) begin
            bad++; $display("FAIL flush_idle got=%b want=00", {bus.if_valid, bus.mem_req});
        end
        bus.if_flush = 0;
        tick();
        total++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h600}) begin
            bad++; $display("FAIL flush_regrant got=%h want=%h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h600});
        end
        bus.if_req = 0; bus.mem_ready = 1;
        tick();
        bus.mem_ready = 0;
        tick();
    endtask

    task automatic test_misalign;
        bus.d_req = 1; bus.d_we = 0; bus.d_size = 2; bus.d_addr = 32'h6;
        tick();
        total++;
        if ({bus.d_misalign, bus.mem_req, bus.stall} !== 3'b100) begin
            bad++; $display("FAIL misalign got=%b want=100", {bus.d_misalign, bus.mem_req, bus.stall});
        end
        bus.d_req = 0;
        tick();
        total++;
        if ({bus.d_misalign, bus.mem_req} !== 2'b00) begin
            bad++; $display("FAIL misalign_pulse got=%b want=00", {bus.d_misalign, bus.mem_req});
        end
    endtask

    task automatic test_reset_mid;
        bus.d_req = 1; bus.d_we = 0; bus.d_size = 2; bus.d_addr = 32'h40;
        tick();
        reset = 0; bus.d_req = 0;
        tick();
        total++;
        if ({bus.mem_req, bus.mem_be, bus.mem_addr, bus.d_valid, bus.stall} !== 39'd0) begin
            bad++; $display("FAIL rst_mid got=%h want=0", {bus.mem_req, bus.mem_be, bus.mem_addr, bus.d_valid, bus.stall});
        end
        reset = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h77777777;
        tick();
        total++;
        if ({bus.d_valid, bus.mem_req, bus.d_rdata} !== 34'd0) begin
            bad++; $display("FAIL rst_late_ready got=%h want=0", {bus.d_valid, bus.mem_req, bus.d_rdata});
        end
        bus.mem_ready = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_byte_load();
        test_lanes();
        test_back_to_back();
        test_starvation();
        test_flush();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
